led_scheduler: RTL and testbench

Time-slicing scheduler for the board's six-LED bank (led[8:3]). Several status sources on the clk100 domain each request the bank with a pattern and a steady/blink flag. The block grants the bank round-robin, holds each grant for a fixed dwell time and blanks the LEDs between grants. It replaces per-source direct LED drive in board test builds.

---
 rtl/led_scheduler.sv | 139 +++++++++++++
 tb/tb_led_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/led_scheduler.sv
// Round-robin time-slicing scheduler for the six-LED bank: each requester owns the
// LEDs for a fixed dwell, optionally blinking, with one dark cycle between owners.
module led_scheduler #(
   parameter int N_REQ       = 4,
   parameter int TICK_CYCLES = 100000,
   parameter int DWELL_TICKS = 2000,
   parameter int BLINK_TICKS = 250
) (
   input  logic               clk100,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [6*N_REQ-1:0] pattern,
   input  logic [N_REQ-1:0]   blink,
   output logic [5:0]         led,
   output logic [N_REQ-1:0]   grant,
   output logic [N_REQ-1:0]   done
);

   localparam int RW = $clog2(N_REQ);
   localparam int PW = $clog2(TICK_CYCLES) + 1;
   localparam int DW = $clog2(DWELL_TICKS) + 1;
   localparam int BW = $clog2(BLINK_TICKS) + 1;
   localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_CYCLES - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t         state_reg, state_next;
   logic [5:0]     led_reg, led_next;
   logic [N_REQ-1:0] grant_reg, grant_next;
   logic [N_REQ-1:0] done_reg, done_next;
   logic [RW-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [PW-1:0]  prescaler_reg, prescaler_next;
   logic [DW-1:0]  dwell_cnt_reg, dwell_cnt_next;
   logic [BW-1:0]  blink_cnt_reg, blink_cnt_next;
   logic           phase_reg, phase_next;

   logic [5:0]     pat [N_REQ];
   logic           win_found;
   logic [RW-1:0]  win_idx;
   logic           tick, blink_wrap, expire, abort, phase_upd;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pat
      assign pat[gi] = pattern[6*gi +: 6];
   end

   // Walk downward so the candidate nearest rr_ptr+1 is assigned last and wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[(int'(rr_ptr_reg) + k) % N_REQ]) begin
            win_found = 1'b1;
            win_idx   = RW'((int'(rr_ptr_reg) + k) % N_REQ);
         end
      end
   end

   // During SHOW the owner index is always rr_ptr.
   assign tick       = (prescaler_reg == PRE_LAST);
   assign blink_wrap = tick && (blink_cnt_reg == BLINK_LAST);
   assign expire     = tick && (dwell_cnt_reg == DWELL_LAST);
   assign abort      = ~req[rr_ptr_reg];
   assign phase_upd  = blink_wrap ? ~phase_reg : phase_reg;

   always_comb begin
      state_next     = state_reg;
      led_next       = '0;
      grant_next     = grant_reg;
      done_next      = '0;
      rr_ptr_next    = rr_ptr_reg;
      prescaler_next = prescaler_reg;
      dwell_cnt_next = dwell_cnt_reg;
      blink_cnt_next = blink_cnt_reg;
      phase_next     = phase_reg;
      case (state_reg)
         IDLE: begin
            grant_next     = '0;
            prescaler_next = '0;
            dwell_cnt_next = '0;
            blink_cnt_next = '0;
            phase_next     = 1'b1;
            if (win_found) begin
               state_next          = SHOW;
               grant_next[win_idx] = 1'b1;
               rr_ptr_next         = win_idx;
               led_next            = pat[win_idx];
            end
         end
         SHOW: begin
            if (expire || abort) begin
               state_next = IDLE;
               grant_next = '0;
               done_next  = grant_reg;
            end else begin
               prescaler_next = tick ? '0 : prescaler_reg + PW'(1);
               dwell_cnt_next = tick ? dwell_cnt_reg + DW'(1) : dwell_cnt_reg;
               if (blink_wrap)
                  blink_cnt_next = '0;
               else if (tick)
                  blink_cnt_next = blink_cnt_reg + BW'(1);
               phase_next = phase_upd;
               led_next   = pat[rr_ptr_reg] & {6{phase_upd | ~blink[rr_ptr_reg]}};
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         led_reg       <= '0;
         grant_reg     <= '0;
         done_reg      <= '0;
         rr_ptr_reg    <= RW'(N_REQ - 1);
         prescaler_reg <= '0;
         dwell_cnt_reg <= '0;
         blink_cnt_reg <= '0;
         phase_reg     <= 1'b1;
      end else begin
         state_reg     <= state_next;
         led_reg       <= led_next;
         grant_reg     <= grant_next;
         done_reg      <= done_next;
         rr_ptr_reg    <= rr_ptr_next;
         prescaler_reg <= prescaler_next;
         dwell_cnt_reg <= dwell_cnt_next;
         blink_cnt_reg <= blink_cnt_next;
         phase_reg     <= phase_next;
      end
   end

   assign led   = led_reg;
   assign grant = grant_reg;
   assign done  = done_reg;

endmodule

// File: tb/tb_led_scheduler.sv
// Directed bench for led_scheduler: 4 sources, 4-cycle tick, 3-tick dwell, 1-tick blink.
module tb_led_scheduler;

   logic        clk100 = 1'b0;
   logic        rst_n  = 1'b1;
   logic [3:0]  req    = '0;
   logic [23:0] pattern = {6'h0C, 6'h3F, 6'h15, 6'h2A};
   logic [3:0]  blink  = '0;
   logic [5:0]  led;
   logic [3:0]  grant;
   logic [3:0]  done;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   led_scheduler #(
      .N_REQ(4), .TICK_CYCLES(4), .DWELL_TICKS(3), .BLINK_TICKS(1)
   ) dut (
      .clk100(clk100), .rst_n(rst_n), .req(req), .pattern(pattern),
      .blink(blink), .led(led), .grant(grant), .done(done)
   );

   always #5 clk100 = ~clk100;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [5:0] l,
                          input logic [3:0] d);
      chk($sformatf("%s grant", tag), 32'(grant), 32'(g));
      chk($sformatf("%s led", tag), 32'(led), 32'(l));
      chk($sformatf("%s done", tag), 32'(done), 32'(d));
   endtask

   // Full 12-cycle steady grant followed by the dark handover cycle.
   task automatic show_and_gap(input string tag, input logic [3:0] g, input logic [5:0] l);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk100);
         chk_out($sformatf("%s show c%0d", tag, c), g, l, 4'b0000);
      end
      @(negedge clk100);
      chk_out($sformatf("%s gap", tag), 4'b0000, 6'h00, g);
      $display("txn %s: grant=%b led=%h then done=%b", tag, g, l, done);
   endtask

   initial begin
      // Reset state, with requests present while reset is held.
      #1 rst_n = 1'b0;
      req = 4'b1111;
      @(negedge clk100);
      chk_out("reset", 4'b0000, 6'h00, 4'b0000);
      @(negedge clk100);
      chk_out("reset held", 4'b0000, 6'h00, 4'b0000);
      req   = 4'b0000;
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk100);
         chk($sformatf("idle c%0d", c), 32'({led, grant, done}), 32'h0);
      end
      $display("txn idle: 50 cycles dark");

      // Round robin starting from source 0 after reset.
      req = 4'b1111;
      show_and_gap("rr0", 4'b0001, 6'h2A);
      show_and_gap("rr1", 4'b0010, 6'h15);
      show_and_gap("rr2", 4'b0100, 6'h3F);
      show_and_gap("rr3", 4'b1000, 6'h0C);
      show_and_gap("rr4", 4'b0001, 6'h2A);
      req = 4'b0000;
      @(negedge clk100);
      chk_out("rr stop", 4'b0000, 6'h00, 4'b0000);

      // Single steady requester: expiry, one-cycle gap, re-grant.
      req = 4'b0001;
      show_and_gap("single", 4'b0001, 6'h2A);
      @(negedge clk100);
      chk_out("single regrant", 4'b0001, 6'h2A, 4'b0000);
      $display("txn single: regranted grant=%b", grant);

      // Abort of source 0, then source 1 aborted in its 5th SHOW cycle.
      req = 4'b0110;
      @(negedge clk100);
      chk_out("abort0", 4'b0000, 6'h00, 4'b0001);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk100);
         chk_out($sformatf("src1 c%0d", c), 4'b0010, 6'h15, 4'b0000);
      end
      req   = 4'b0100;
      blink = 4'b0100;
      @(negedge clk100);
      chk_out("abort1", 4'b0000, 6'h00, 4'b0010);
      $display("txn abort: source 1 aborted, done=%b", done);

      // Blinking source 2; its request drops on the same cycle the dwell expires.
      for (int c = 0; c < 12; c++) begin
         @(negedge clk100);
         chk_out($sformatf("blink c%0d", c), 4'b0100,
                 (c < 4 || c >= 8) ? 6'h3F : 6'h00, 4'b0000);
         if (c == 11) req = 4'b0000;
      end
      @(negedge clk100);
      chk_out("blink gap", 4'b0000, 6'h00, 4'b0100);
      @(negedge clk100);
      chk_out("blink after", 4'b0000, 6'h00, 4'b0000);
      $display("txn blink: source 2 on/off/on, single done");

      // Source 3 wins from rr_ptr=2; reset mid-grant between clock edges.
      blink = 4'b0000;
      req   = 4'b1001;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk100);
         chk_out($sformatf("src3 c%0d", c), 4'b1000, 6'h0C, 4'b0000);
      end
      #2 rst_n = 1'b0;
      #1 chk_out("async reset", 4'b0000, 6'h00, 4'b0000);
      @(negedge clk100);
      chk_out("reset no done", 4'b0000, 6'h00, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk100);
      chk_out("post reset", 4'b0001, 6'h2A, 4'b0000);
      $display("txn reset: mid-grant reset, source 0 wins after release");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
